vdp18_timing_gen: RTL and testbench

- Parametrised successor to the TMS9918A timing controller.
- Owns the horizontal and vertical counters instead of receiving them, and supports NTSC/PAL frame selection and 192/212 active lines.
- Decodes VRAM access slots per mode, grants CPU VRAM slots through a req/gnt handshake, and holds a latched frame IRQ with acknowledge.
- Sits between the register file and the VRAM address/sprite/pattern engines, in place of the fixed-geometry controller.

---
 rtl/vdp18_timing_gen.sv | 240 ++++++++++++++++++++++++
 tb/tb_vdp18_timing_gen.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vdp18_timing_gen.sv
// vdp18 timing generator: owns the pixel/line counters, decodes VRAM slots, grants CPU slots, raises the frame IRQ.
// Optional macro VDP18_LINE_IRQ_EN adds a programmable line interrupt (line_irq_i / line_irq_o).
package vdp18_pkg;
    typedef enum logic [1:0] {
        OPMODE_GRAPH1 = 2'd0,
        OPMODE_GRAPH2 = 2'd1,
        OPMODE_MULTIC = 2'd2,
        OPMODE_TEXTM  = 2'd3
    } opmode_t;

    typedef enum logic [3:0] {
        AC_CPU  = 4'd0,
        AC_PNT  = 4'd1,
        AC_PCT  = 4'd2,
        AC_PGT  = 4'd3,
        AC_STST = 4'd4,
        AC_SATY = 4'd5,
        AC_SATX = 4'd6,
        AC_SATN = 4'd7,
        AC_SATC = 4'd8,
        AC_SPTH = 4'd9,
        AC_SPTL = 4'd10
    } access_t;
endpackage

module vdp18_timing_gen
    import vdp18_pkg::*;
#(
    parameter int unsigned H_TOTAL      = 342,
    parameter int unsigned H_ACTIVE     = 256,
    parameter int unsigned H_ACTIVE_TXT = 240,
    parameter int unsigned V_TOTAL_NTSC = 262,
    parameter int unsigned V_TOTAL_PAL  = 313,
    parameter int unsigned V_ACTIVE_LO  = 192,
    parameter int unsigned V_ACTIVE_HI  = 212,
    parameter int unsigned SPR_PER_LINE = 4
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       clk_en_5m37_i,
    input  opmode_t    opmode_i,
    input  logic       pal_i,
    input  logic       lines212_i,
    input  logic       reg_blank_i,
    input  logic       reg_size1_i,
    input  logic       stop_sprite_i,
    input  logic       cpu_req_i,
    input  logic       irq_ack_i,
    output logic [8:0] hcnt_o,
    output logic [8:0] vcnt_o,
    output logic       vert_inc_o,
    output logic       clk_en_acc_o,
    output access_t    access_type_o,
    output logic       cpu_gnt_o,
    output logic       hor_active_o,
    output logic       vert_active_o,
`ifdef VDP18_LINE_IRQ_EN
    input  logic [8:0] line_irq_i,
    output logic       line_irq_o,
`endif
    output logic       irq_o
);

    localparam logic [8:0] HT_M1     = 9'(H_TOTAL - 1);
    localparam logic [8:0] HA_M1     = 9'(H_ACTIVE - 1);
    localparam logic [8:0] HA_TXT_M1 = 9'(H_ACTIVE_TXT - 1);
    localparam logic [8:0] VT_NTSC   = 9'(V_TOTAL_NTSC);
    localparam logic [8:0] VT_PAL    = 9'(V_TOTAL_PAL);
    localparam logic [8:0] VA_LO     = 9'(V_ACTIVE_LO);
    localparam logic [8:0] VA_HI     = 9'(V_ACTIVE_HI);
    localparam logic [7:0] SPR_BASE  = 8'd128;
    localparam logic [7:0] SPR_END   = 8'(128 + 6 * SPR_PER_LINE);
    localparam logic [7:0] STST_LAST = 8'd164;
    localparam logic [7:0] GFX_SLOTS = 8'd128;
    localparam logic [7:0] TXT_SLOTS = 8'd120;

    logic [8:0] hcnt_r, vcnt_r;
    logic       pal_r, l212_r;
    logic       hor_active_r, vert_active_r, spr_line_r;
    logic       req_d_r, pend_r, frame_irq_r, line_irq_r;

    logic [8:0] v_total_s, v_active_s, v_next_s, h_end_s;
    logic       h_wrap_s, v_wrap_s, vert_inc_s, clk_en_acc_s;
    logic       spr_range_s, req_rise_s, gnt_s;
    logic [7:0] slot_s, spr_off_s;
    logic [2:0] spr_idx_s;
    logic [1:0] txt_phase_s;
    access_t    access_s;

    assign v_total_s    = pal_r ? VT_PAL : VT_NTSC;
    assign v_active_s   = l212_r ? VA_HI : VA_LO;
    assign h_end_s      = (opmode_i == OPMODE_TEXTM) ? HA_TXT_M1 : HA_M1;
    assign h_wrap_s     = (hcnt_r == HT_M1);
    assign v_wrap_s     = (vcnt_r == (v_total_s - 9'd1));
    assign v_next_s     = v_wrap_s ? 9'd0 : (vcnt_r + 9'd1);
    assign vert_inc_s   = clk_en_5m37_i & h_wrap_s;
    assign clk_en_acc_s = clk_en_5m37_i & hcnt_r[0];
    // Line -1 (last line of the frame) is included so sprites for line 0 get fetched.
    assign spr_range_s  = (v_next_s == (v_total_s - 9'd1)) || (v_next_s < v_active_s);
    assign slot_s       = hcnt_r[8:1];
    assign spr_off_s    = slot_s - SPR_BASE;
    assign spr_idx_s    = 3'(spr_off_s % 8'd6);
    assign txt_phase_s  = 2'(slot_s % 8'd3);
    assign req_rise_s   = cpu_req_i & ~req_d_r;
    assign gnt_s        = clk_en_acc_s & (access_s == AC_CPU) & pend_r;

    // VRAM slot decode from counter state and mode
    always_comb begin
        access_s = AC_CPU;
        if (opmode_i == OPMODE_TEXTM) begin
            if (vert_active_r && (slot_s < TXT_SLOTS)) begin
                case (txt_phase_s)
                    2'd0:    access_s = AC_PNT;
                    2'd2:    access_s = AC_PGT;
                    default: access_s = AC_CPU;
                endcase
            end else begin
                access_s = AC_CPU;
            end
        end else if (spr_line_r && (slot_s >= SPR_BASE) && (slot_s < SPR_END)) begin
            case (spr_idx_s)
                3'd0:    access_s = AC_SATY;
                3'd1:    access_s = AC_SATX;
                3'd2:    access_s = AC_SATN;
                3'd3:    access_s = AC_SATC;
                3'd4:    access_s = AC_SPTH;
                3'd5:    access_s = reg_size1_i ? AC_SPTL : AC_CPU;
                default: access_s = AC_CPU;
            endcase
        end else if (spr_line_r && (slot_s >= SPR_END) && (slot_s <= STST_LAST)) begin
            access_s = AC_STST;
        end else if (vert_active_r && (slot_s < GFX_SLOTS)) begin
            case (slot_s[1:0])
                2'd0:    access_s = AC_PNT;
                2'd1:    access_s = (opmode_i == OPMODE_MULTIC) ? AC_CPU : AC_PCT;
                2'd2:    access_s = AC_PGT;
                default: access_s = AC_CPU;
            endcase
        end else begin
            access_s = AC_CPU;
        end
    end

    // Pixel/line counters; frame geometry latched at the frame wrap only
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            hcnt_r <= 9'd0;
            vcnt_r <= 9'd0;
            pal_r  <= 1'b0;
            l212_r <= 1'b0;
        end else if (clk_en_5m37_i) begin
            if (h_wrap_s) begin
                hcnt_r <= 9'd0;
                vcnt_r <= v_next_s;
                if (v_wrap_s) begin
                    pal_r  <= pal_i;
                    l212_r <= lines212_i;
                end
            end else begin
                hcnt_r <= hcnt_r + 9'd1;
            end
        end
    end

    // Display window and sprite-line flags
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            hor_active_r  <= 1'b0;
            vert_active_r <= 1'b0;
            spr_line_r    <= 1'b0;
        end else begin
            if (clk_en_5m37_i) begin
                if (h_wrap_s && !reg_blank_i) begin
                    hor_active_r <= 1'b1;
                end else if (hcnt_r == h_end_s) begin
                    hor_active_r <= 1'b0;
                end
            end
            if (vert_inc_s) begin
                if (v_next_s == 9'd0) begin
                    vert_active_r <= ~reg_blank_i;
                end else if (reg_blank_i || (v_next_s == v_active_s)) begin
                    vert_active_r <= 1'b0;
                end
            end
            if (vert_inc_s) begin
                spr_line_r <= spr_range_s & ~reg_blank_i;
            end else if (stop_sprite_i || reg_blank_i) begin
                spr_line_r <= 1'b0;
            end
        end
    end

    // CPU request capture and interrupt latches; a new edge in the grant cycle re-arms
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            req_d_r     <= 1'b0;
            pend_r      <= 1'b0;
            frame_irq_r <= 1'b0;
            line_irq_r  <= 1'b0;
        end else begin
            req_d_r <= cpu_req_i;
            if (gnt_s) begin
                pend_r <= req_rise_s;
            end else if (req_rise_s) begin
                pend_r <= 1'b1;
            end
            if (vert_inc_s && (v_next_s == v_active_s)) begin
                frame_irq_r <= 1'b1;
            end else if (irq_ack_i) begin
                frame_irq_r <= 1'b0;
            end
`ifdef VDP18_LINE_IRQ_EN
            if (vert_inc_s && (v_next_s == line_irq_i)) begin
                line_irq_r <= 1'b1;
            end else if (irq_ack_i) begin
                line_irq_r <= 1'b0;
            end
`else
            line_irq_r <= 1'b0;
`endif
        end
    end

    assign hcnt_o        = hcnt_r;
    assign vcnt_o        = vcnt_r;
    assign vert_inc_o    = vert_inc_s;
    assign clk_en_acc_o  = clk_en_acc_s;
    assign access_type_o = access_s;
    assign cpu_gnt_o     = gnt_s;
    assign hor_active_o  = hor_active_r;
    assign vert_active_o = vert_active_r;
`ifdef VDP18_LINE_IRQ_EN
    assign line_irq_o    = line_irq_r;
    assign irq_o         = frame_irq_r | line_irq_r;
`else
    assign irq_o         = frame_irq_r | line_irq_r;
`endif

endmodule

// File: tb/tb_vdp18_timing_gen.sv
// Randomised bench for vdp18_timing_gen against a frame-position reference model (shortened vertical geometry).
module tb_vdp18_timing_gen;
    import vdp18_pkg::*;

    localparam int HT      = 342;
    localparam int HA      = 256;
    localparam int HA_TXT  = 240;
    localparam int VT_NTSC = 20;
    localparam int VT_PAL  = 25;
    localparam int VA_LO   = 12;
    localparam int VA_HI   = 14;
    localparam int SPR     = 4;

    logic       clk = 1'b0;
    logic       reset_n, clk_en, pal, lines212, blank, size1, stop_spr, cpu_req, ack;
    opmode_t    opmode;
    logic [8:0] hcnt, vcnt;
    logic       vert_inc, clk_en_acc, cpu_gnt, hor_active, vert_active, irq;
    access_t    access_type;
`ifdef VDP18_LINE_IRQ_EN
    logic [8:0] line_irq;
    logic       line_irq_out;
`endif

    always #5 clk = ~clk;

    vdp18_timing_gen #(
        .H_TOTAL(HT), .H_ACTIVE(HA), .H_ACTIVE_TXT(HA_TXT),
        .V_TOTAL_NTSC(VT_NTSC), .V_TOTAL_PAL(VT_PAL),
        .V_ACTIVE_LO(VA_LO), .V_ACTIVE_HI(VA_HI), .SPR_PER_LINE(SPR)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n), .clk_en_5m37_i(clk_en), .opmode_i(opmode),
        .pal_i(pal), .lines212_i(lines212), .reg_blank_i(blank), .reg_size1_i(size1),
        .stop_sprite_i(stop_spr), .cpu_req_i(cpu_req), .irq_ack_i(ack),
        .hcnt_o(hcnt), .vcnt_o(vcnt), .vert_inc_o(vert_inc), .clk_en_acc_o(clk_en_acc),
        .access_type_o(access_type), .cpu_gnt_o(cpu_gnt), .hor_active_o(hor_active),
        .vert_active_o(vert_active),
`ifdef VDP18_LINE_IRQ_EN
        .line_irq_i(line_irq), .line_irq_o(line_irq_out),
`endif
        .irq_o(irq)
    );

    int checks, errors;
    // model: position in enables since frame start, plus the window/irq/request flags
    int m_pos, m_lines;
    bit m_l212, m_hact, m_vact, m_spr, m_pend, m_req_prev, m_irqf, m_irql;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic access_t exp_acc(input opmode_t m, input int h, input bit va, input bit sf, input bit sz1);
        int s;
        s = h / 2;
        if (m == OPMODE_TEXTM) begin
            if (va && s < 120 && s % 3 == 0) return AC_PNT;
            if (va && s < 120 && s % 3 == 2) return AC_PGT;
            return AC_CPU;
        end
        if (sf && s >= 128 && s < 128 + 6 * SPR) begin
            case ((s - 128) % 6)
                0: return AC_SATY;
                1: return AC_SATX;
                2: return AC_SATN;
                3: return AC_SATC;
                4: return AC_SPTH;
                default: return sz1 ? AC_SPTL : AC_CPU;
            endcase
        end
        if (sf && s >= 128 + 6 * SPR && s <= 164) return AC_STST;
        if (va && s < 128) begin
            case (s % 4)
                0: return AC_PNT;
                1: return (m == OPMODE_MULTIC) ? AC_CPU : AC_PCT;
                2: return AC_PGT;
                default: return AC_CPU;
            endcase
        end
        return AC_CPU;
    endfunction

    task automatic model_reset();
        m_pos = 0; m_lines = VT_NTSC; m_l212 = 0; m_hact = 0; m_vact = 0;
        m_spr = 0; m_pend = 0; m_req_prev = 0; m_irqf = 0; m_irql = 0;
    endtask

    task automatic compare_all();
        int h, v;
        bit vinc, g;
        access_t a;
        h = m_pos % HT;
        v = m_pos / HT;
        vinc = clk_en && (h == HT - 1);
        a = exp_acc(opmode, h, m_vact, m_spr, size1);
        g = clk_en && (h % 2 == 1) && (a == AC_CPU) && m_pend;
        chk("hcnt", int'(hcnt), h);
        chk("vcnt", int'(vcnt), v);
        chk("vert_inc", int'(vert_inc), int'(vinc));
        chk("clk_en_acc", int'(clk_en_acc), int'(clk_en && (h % 2 == 1)));
        chk("access_type", int'(access_type), int'(a));
        chk("cpu_gnt", int'(cpu_gnt), int'(g));
        chk("hor_active", int'(hor_active), int'(m_hact));
        chk("vert_active", int'(vert_active), int'(m_vact));
        chk("irq", int'(irq), int'(m_irqf | m_irql));
`ifdef VDP18_LINE_IRQ_EN
        chk("line_irq", int'(line_irq_out), int'(m_irql));
`endif
    endtask

    // advance the model across the coming clock edge using the inputs now applied
    task automatic step_model();
        int h, v, nv, vlines;
        bit vinc, rise, g;
        access_t a;
        if (!reset_n) begin
            model_reset();
        end else begin
            h = m_pos % HT;
            v = m_pos / HT;
            vinc = clk_en && (h == HT - 1);
            a = exp_acc(opmode, h, m_vact, m_spr, size1);
            g = clk_en && (h % 2 == 1) && (a == AC_CPU) && m_pend;
            vlines = m_l212 ? VA_HI : VA_LO;
            nv = (v == m_lines - 1) ? 0 : v + 1;
            rise = cpu_req && !m_req_prev;
            if (clk_en) begin
                if (h == HT - 1 && !blank) m_hact = 1;
                else if (h == ((opmode == OPMODE_TEXTM) ? HA_TXT - 1 : HA - 1)) m_hact = 0;
            end
            if (vinc) begin
                if (nv == 0) m_vact = !blank;
                else if (blank || nv == vlines) m_vact = 0;
            end
            if (vinc) m_spr = ((nv == m_lines - 1) || (nv < vlines)) && !blank;
            else if (stop_spr || blank) m_spr = 0;
            if (g) m_pend = rise;
            else if (rise) m_pend = 1;
            m_req_prev = cpu_req;
            if (vinc && nv == vlines) m_irqf = 1;
            else if (ack) m_irqf = 0;
`ifdef VDP18_LINE_IRQ_EN
            if (vinc && nv == int'(line_irq)) m_irql = 1;
            else if (ack) m_irql = 0;
`endif
            if (clk_en) begin
                m_pos++;
                if (m_pos == m_lines * HT) begin
                    m_pos = 0;
                    m_lines = pal ? VT_PAL : VT_NTSC;
                    m_l212 = lines212;
                end
            end
        end
    endtask

    task automatic edge_check();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        int wraps, prev_v, gnt_h, gnt_cnt, irq_rise_v, mh, mv;
        int last_v[2];
        checks = 0; errors = 0;
        reset_n = 0; clk_en = 0; pal = 0; lines212 = 0; blank = 0; size1 = 0;
        stop_spr = 0; cpu_req = 0; ack = 0; opmode = OPMODE_GRAPH2;
`ifdef VDP18_LINE_IRQ_EN
        line_irq = 9'd31;
`endif
        model_reset();

        // hand-computed slot decodes pinning the model
        chk("pin_g2_pnt", int'(exp_acc(OPMODE_GRAPH2, 0, 1, 0, 0)), int'(AC_PNT));
        chk("pin_g2_pct", int'(exp_acc(OPMODE_GRAPH2, 2, 1, 0, 0)), int'(AC_PCT));
        chk("pin_g2_pgt", int'(exp_acc(OPMODE_GRAPH2, 4, 1, 0, 0)), int'(AC_PGT));
        chk("pin_g2_cpu", int'(exp_acc(OPMODE_GRAPH2, 6, 1, 0, 0)), int'(AC_CPU));
        chk("pin_mc_slot1", int'(exp_acc(OPMODE_MULTIC, 3, 1, 0, 0)), int'(AC_CPU));
        chk("pin_txt_s4", int'(exp_acc(OPMODE_TEXTM, 8, 1, 0, 0)), int'(AC_CPU));
        chk("pin_txt_s5", int'(exp_acc(OPMODE_TEXTM, 11, 1, 0, 0)), int'(AC_PGT));
        chk("pin_spr_sptl", int'(exp_acc(OPMODE_GRAPH1, 266, 0, 1, 0)), int'(AC_CPU));

        repeat (3) begin edge_check(); step_model(); end
        edge_check();
        reset_n = 1; clk_en = 1;
        step_model();
        for (int i = 1; i <= 5; i++) begin
            edge_check();
            if (i == 5) chk("hcnt_after_5", int'(hcnt), 5);
            step_model();
        end

        // two frames: pal switched mid-frame, CPU grant timing, IRQ set/ack ordering
        wraps = 0; prev_v = 0; gnt_h = -1; gnt_cnt = 0; irq_rise_v = -1;
        last_v[0] = -1; last_v[1] = -1;
        for (int c = 0; c < 20000 && wraps < 2; c++) begin
            edge_check();
            mh = m_pos % HT;
            mv = m_pos / HT;
            if (irq_rise_v < 0 && irq && wraps == 0) irq_rise_v = int'(vcnt);
            if (vcnt == 9'd0 && prev_v != 0) begin
                last_v[wraps] = prev_v;
                wraps++;
            end
            prev_v = int'(vcnt);
            if (wraps == 1 && mv == 1 && cpu_gnt) begin
                gnt_cnt++;
                if (gnt_h < 0) gnt_h = int'(hcnt);
            end
            if (wraps == 1 && mv == 2 && mh == 1) chk("irq_ack_clear", int'(irq), 0);
            if (wraps == 1 && mv == 12 && mh == 0) chk("irq_set_wins", int'(irq), 1);
            if (wraps == 1 && mv == 13 && mh == 1) chk("irq_ack_later", int'(irq), 0);
`ifdef VDP18_LINE_IRQ_EN
            if (wraps == 1) line_irq = 9'd5;
            if (wraps == 1 && mv == 5 && mh == 0) chk("line_irq_at_5", int'(line_irq_out), 1);
`endif
            if (wraps == 0 && mv >= 5) pal = 1;
            if (wraps == 1 && mv == 1 && mh == 10) cpu_req = 1;
            if (mv == 2) cpu_req = 0;
            ack = (wraps == 1) && ((mv == 2 && mh == 0) || (mv == 11 && mh == HT - 1) || (mv == 13 && mh == 0));
            step_model();
        end
        chk("frame_wraps", wraps, 2);
        chk("ntsc_last_line", last_v[0], VT_NTSC - 1);
        chk("pal_last_line", last_v[1], VT_PAL - 1);
        chk("irq_rise_line", irq_rise_v, VA_LO);
        chk("gnt_hcnt", gnt_h, 15);
        chk("gnt_count", gnt_cnt, 1);

        // randomised traffic against the model
        for (int c = 0; c < 30000; c++) begin
            edge_check();
            if (!reset_n) reset_n = 1;
            else if ($urandom_range(0, 9999) == 0) reset_n = 0;
            clk_en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 399) == 0) opmode = opmode_t'($urandom_range(0, 3));
            if ($urandom_range(0, 2999) == 0) pal = ~pal;
            if ($urandom_range(0, 2999) == 0) lines212 = ~lines212;
            if ($urandom_range(0, 1999) == 0) blank = ~blank;
            if ($urandom_range(0, 999) == 0) size1 = ~size1;
            stop_spr = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 7) == 0) cpu_req = ~cpu_req;
            ack = ($urandom_range(0, 299) == 0);
`ifdef VDP18_LINE_IRQ_EN
            if ($urandom_range(0, 4999) == 0) line_irq = 9'($urandom_range(0, 24));
`endif
            step_model();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
